alu_mc: RTL and testbench

//  Parametrised multi-cycle ALU for the pipelined CPU EX stage; successor to the single-cycle 32-bit ALU.

---
 rtl/alu_mc_pkg.sv | 19 +
 rtl/alu_mc_muldiv.sv | 150 +++++++++++++++
 rtl/alu_mc.sv | 163 ++++++++++++++++
 tb/tb_alu_mc.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mc_pkg.sv
// Shared definitions for the multi-cycle ALU: aluc[2:0] operation selects
// and the sequencing FSM state encoding.
package alu_mc_pkg;

    localparam logic [2:0] ALU_ADDSUB = 3'd0;
    localparam logic [2:0] ALU_MUL    = 3'd1;
    localparam logic [2:0] ALU_LOGIC  = 3'd2;
    localparam logic [2:0] ALU_XOR    = 3'd3;
    localparam logic [2:0] ALU_LUI    = 3'd4;
    localparam logic [2:0] ALU_SHIFT  = 3'd5;
    localparam logic [2:0] ALU_DIV    = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_mc_muldiv.sv
// Iterative signed multiplier, one bit per cycle, working on operand
// magnitudes with a sign fix-up on the way out. With ALU_MC_DIV_EN defined
// the same registers also run a restoring divider.
// The first iteration is folded into the start cycle so that the result is
// ready WIDTH cycles after start; `last` flags the final iteration cycle.
module alu_mc_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
`ifdef ALU_MC_DIV_EN
    input  logic             op_div,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi
);

    localparam int CNTW = $clog2(WIDTH);

    logic             busy_q, busy_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] mag_b_q, mag_b_d;
    logic             neg_lo_q, neg_lo_d;
`ifdef ALU_MC_DIV_EN
    logic             div_q, div_d;
    logic             div0_q, div0_d;
    logic             neg_hi_q, neg_hi_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             qbit;
`endif

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH-1:0]   cur_hi, cur_lo, cur_b;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [2*WIDTH-1:0] prod, prod_s;

    // One shift-add (or shift-subtract) step, plus operand load and down-count
    always_comb begin
        mag_a   = a[WIDTH-1] ? (~a + 1'b1) : a;
        mag_b   = b[WIDTH-1] ? (~b + 1'b1) : b;
        cur_hi  = start ? '0 : hi_q;
        cur_lo  = start ? mag_a : lo_q;
        cur_b   = start ? mag_b : mag_b_q;
        sum     = {1'b0, cur_hi} + (cur_lo[0] ? {1'b0, cur_b} : '0);
        step_hi = sum[WIDTH:1];
        step_lo = {sum[0], cur_lo[WIDTH-1:1]};
`ifdef ALU_MC_DIV_EN
        shifted = {cur_hi, cur_lo[WIDTH-1]};
        diff    = shifted - {1'b0, cur_b};
        qbit    = ~diff[WIDTH];
        if (start ? op_div : div_q) begin
            step_hi = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
            step_lo = {cur_lo[WIDTH-2:0], qbit};
        end
        div_d    = div_q;
        div0_d   = div0_q;
        neg_hi_d = neg_hi_q;
        a_d      = a_q;
`endif
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        mag_b_d  = mag_b_q;
        neg_lo_d = neg_lo_q;
        if (start) begin
            busy_d   = 1'b1;
            cnt_d    = CNTW'(WIDTH - 2);
            hi_d     = step_hi;
            lo_d     = step_lo;
            mag_b_d  = mag_b;
            neg_lo_d = a[WIDTH-1] ^ b[WIDTH-1];
`ifdef ALU_MC_DIV_EN
            div_d    = op_div;
            div0_d   = (b == '0);
            neg_hi_d = a[WIDTH-1];
            a_d      = a;
`endif
        end else if (busy_q) begin
            hi_d  = step_hi;
            lo_d  = step_lo;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end
        end
    end

    assign last = busy_q & (cnt_q == '0);

    // Restore signs: product negated as a whole, quotient and remainder separately
    always_comb begin
        prod   = {hi_q, lo_q};
        prod_s = neg_lo_q ? (~prod + 1'b1) : prod;
        res_lo = prod_s[WIDTH-1:0];
        res_hi = prod_s[2*WIDTH-1:WIDTH];
`ifdef ALU_MC_DIV_EN
        if (div_q) begin
            if (div0_q) begin
                res_lo = '1;
                res_hi = a_q;
            end else begin
                res_lo = neg_lo_q ? (~lo_q + 1'b1) : lo_q;
                res_hi = neg_hi_q ? (~hi_q + 1'b1) : hi_q;
            end
        end
`endif
    end

    // Iteration state registers; reset abandons any op in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            mag_b_q  <= '0;
            neg_lo_q <= 1'b0;
`ifdef ALU_MC_DIV_EN
            div_q    <= 1'b0;
            div0_q   <= 1'b0;
            neg_hi_q <= 1'b0;
            a_q      <= '0;
`endif
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            mag_b_q  <= mag_b_d;
            neg_lo_q <= neg_lo_d;
`ifdef ALU_MC_DIV_EN
            div_q    <= div_d;
            div0_q   <= div0_d;
            neg_hi_q <= neg_hi_d;
            a_q      <= a_d;
`endif
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU for the EX stage with valid/ready handshakes on both sides.
// Single-cycle ops are registered straight into the output; MUL (and DIV when
// ALU_MC_DIV_EN is defined) are handed to alu_mc_muldiv and the FSM waits.
//
// state   | meaning
// ST_IDLE | can accept; single-cycle results load the output regs here
// ST_BUSY | iterative multiply/divide in progress, inputs refused
// ST_DONE | iterations finished; result loads into output regs on exit
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       aluc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] r_hi,
    output logic             z,
    output logic             ov
);

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] r_hi_q, r_hi_d;
    logic             z_q, z_d;
    logic             ov_q, ov_d;

    logic [2:0]       sel;
    logic             accept, is_long, md_start, md_last;
    logic [WIDTH-1:0] md_lo, md_hi;
    logic [WIDTH-1:0] sc_r, addsub;
    logic             sc_ov;

    assign sel      = aluc[2:0];
    assign in_ready = ~reset & (state_q == ST_IDLE) & (~out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;
`ifdef ALU_MC_DIV_EN
    assign is_long  = (sel == ALU_MUL) | (sel == ALU_DIV);
`else
    assign is_long  = (sel == ALU_MUL);
`endif
    assign md_start = accept & is_long;

    alu_mc_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clock  (clock),
        .reset  (reset),
        .start  (md_start),
`ifdef ALU_MC_DIV_EN
        .op_div (sel == ALU_DIV),
`endif
        .a      (a),
        .b      (b),
        .last   (md_last),
        .res_lo (md_lo),
        .res_hi (md_hi)
    );

    // Single-cycle datapath; unused selects give zero with no overflow
    always_comb begin
        sc_r   = '0;
        sc_ov  = 1'b0;
        addsub = aluc[3] ? (a - b) : (a + b);
        case (sel)
            ALU_ADDSUB: begin
                sc_r  = addsub;
                sc_ov = aluc[3]
                      ? ((a[WIDTH-1] ^ b[WIDTH-1]) & (addsub[WIDTH-1] ^ a[WIDTH-1]))
                      : (~(a[WIDTH-1] ^ b[WIDTH-1]) & (addsub[WIDTH-1] ^ a[WIDTH-1]));
            end
            ALU_LOGIC: sc_r = aluc[3] ? (a | b) : (a & b);
            ALU_XOR:   sc_r = a ^ b;
            ALU_LUI:   sc_r = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            ALU_SHIFT: begin
                if (!aluc[3]) begin
                    sc_r = b << a[SHW-1:0];
                end else if (aluc[4]) begin
                    sc_r = $signed(b) >>> a[SHW-1:0];
                end else begin
                    sc_r = b >> a[SHW-1:0];
                end
            end
            ALU_MUL, ALU_DIV: sc_r = '0;
            default:          sc_r = '0;
        endcase
    end

    // Sequencing FSM and output register loading
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        r_d         = r_q;
        r_hi_d      = r_hi_q;
        z_d         = z_q;
        ov_d        = ov_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_long) begin
                        state_d = ST_BUSY;
                    end else begin
                        out_valid_d = 1'b1;
                        r_d         = sc_r;
                        r_hi_d      = '0;
                        z_d         = (sc_r == '0);
                        ov_d        = sc_ov;
                    end
                end
            end
            ST_BUSY: begin
                if (md_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b1;
                r_d         = md_lo;
                r_hi_d      = md_hi;
                z_d         = (md_lo == '0);
                ov_d        = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and result registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            r_q         <= '0;
            r_hi_q      <= '0;
            z_q         <= 1'b1;
            ov_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            r_q         <= r_d;
            r_hi_q      <= r_hi_d;
            z_q         <= z_d;
            ov_q        <= ov_d;
        end
    end

    assign out_valid = out_valid_q;
    assign r         = r_q;
    assign r_hi      = r_hi_q;
    assign z         = z_q;
    assign ov        = ov_q;

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc (WIDTH=32): directed ops with literal expectations plus a
// cycle-by-cycle comparison against an arithmetic reference model.
module tb_alu_mc;

    localparam int W = 32;
`ifdef ALU_MC_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic          clock;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [4:0]    aluc;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  r;
    logic [W-1:0]  r_hi;
    logic          z;
    logic          ov;

    alu_mc #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .aluc      (aluc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r),
        .r_hi      (r_hi),
        .z         (z),
        .ov        (ov)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Reference: plain 64-bit signed arithmetic on the operands
    function automatic void model(input logic [31:0] ma, input logic [31:0] mb, input logic [4:0] mc,
                                  output logic [31:0] mr, output logic [31:0] mrh, output logic mov);
        longint sa, sb, s, p;
        longint lim_hi, lim_lo;
        int     amt;
        lim_hi = 64'sd2147483647;
        lim_lo = -64'sd2147483648;
        sa  = longint'($signed(ma));
        sb  = longint'($signed(mb));
        amt = int'(ma[4:0]);
        mr  = '0;
        mrh = '0;
        mov = 1'b0;
        case (mc[2:0])
            3'd0: begin
                s   = mc[3] ? (sa - sb) : (sa + sb);
                mr  = s[31:0];
                mov = (s > lim_hi) || (s < lim_lo);
            end
            3'd1: begin
                p   = sa * sb;
                mr  = p[31:0];
                mrh = p[63:32];
            end
            3'd2: mr = mc[3] ? (ma | mb) : (ma & mb);
            3'd3: mr = ma ^ mb;
            3'd4: mr = mb << 16;
            3'd5: begin
                if (!mc[3]) mr = mb << amt;
                else if (mc[4]) begin
                    p  = sb >>> amt;
                    mr = p[31:0];
                end else mr = mb >> amt;
            end
            3'd6: begin
                if (DIV_EN) begin
                    if (sb == 0) begin
                        mr  = '1;
                        mrh = ma;
                    end else begin
                        p   = sa / sb;
                        s   = sa % sb;
                        mr  = p[31:0];
                        mrh = s[31:0];
                    end
                end
            end
            default: ;
        endcase
    endfunction

    typedef struct {
        logic [31:0] r;
        logic [31:0] rh;
        logic        z;
        logic        ov;
        int          due;
    } exp_t;

    exp_t q[$];
    int   busy_until = -1;
    bit   prev_rst   = 1'b1;

    // Per-cycle compare against the model (sampled on the falling edge)
    always @(negedge clock) begin
        bit   m_ov, m_busy, m_rdy, lng;
        exp_t e;
        m_ov   = (q.size() > 0) && (cyc >= q[0].due);
        m_busy = (cyc <= busy_until);
        m_rdy  = !reset && !m_busy && (!m_ov || out_ready);
        if (prev_rst) begin
            chk(out_valid == 1'b0, "rst_out_valid", 64'(out_valid), 64'd0);
            chk(r == '0,           "rst_r",         64'(r),         64'd0);
            chk(r_hi == '0,        "rst_r_hi",      64'(r_hi),      64'd0);
            chk(z == 1'b1,         "rst_z",         64'(z),         64'd1);
            chk(ov == 1'b0,        "rst_ov",        64'(ov),        64'd0);
        end else begin
            chk(out_valid === m_ov, "model_out_valid", 64'(out_valid), 64'(m_ov));
            if (m_ov && out_valid) begin
                chk(r === q[0].r,     "model_r",    64'(r),    64'(q[0].r));
                chk(r_hi === q[0].rh, "model_r_hi", 64'(r_hi), 64'(q[0].rh));
                chk(z === q[0].z,     "model_z",    64'(z),    64'(q[0].z));
                chk(ov === q[0].ov,   "model_ov",   64'(ov),   64'(q[0].ov));
            end
        end
        chk(in_ready === m_rdy, "model_in_ready", 64'(in_ready), 64'(m_rdy));
        if (reset) begin
            q.delete();
            busy_until = -1;
        end else begin
            if (m_ov && out_ready) void'(q.pop_front());
            if (in_valid && m_rdy) begin
                model(a, b, aluc, e.r, e.rh, e.ov);
                e.z = (e.r == 32'd0);
                lng = (aluc[2:0] == 3'd1) || (DIV_EN && aluc[2:0] == 3'd6);
                e.due = lng ? cyc + W + 1 : cyc + 1;
                if (lng) busy_until = cyc + W;
                q.push_back(e);
            end
        end
        prev_rst = reset;
    end

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    // Present one op, wait for acceptance and result, compare with literals
    task automatic do_op(input string nm, input logic [31:0] ta, input logic [31:0] tb_v,
                         input logic [4:0] tc, input logic [31:0] er, input logic [31:0] erh,
                         input logic eov, input int elat, output int wait_n);
        int n;
        a        = ta;
        b        = tb_v;
        aluc     = tc;
        in_valid = 1'b1;
        wait_n   = 0;
        @(negedge clock);
        while (!in_ready && wait_n < 100) begin
            wait_n++;
            @(negedge clock);
        end
        if (!in_ready) chk(1'b0, {nm, "_accept_timeout"}, 64'(wait_n), 64'd0);
        @(posedge clock);
        #1 in_valid = 1'b0;
        n = 1;
        @(negedge clock);
        while (!out_valid && n < 100) begin
            n++;
            @(negedge clock);
        end
        chk(n == elat,        {nm, "_latency"}, 64'(n),    64'(elat));
        chk(r == er,          {nm, "_r"},       64'(r),    64'(er));
        chk(r_hi == erh,      {nm, "_r_hi"},    64'(r_hi), 64'(erh));
        chk(ov == eov,        {nm, "_ov"},      64'(ov),   64'(eov));
        chk(z == (er == '0),  {nm, "_z"},       64'(z),    64'(er == '0));
    endtask

    logic [31:0] burst_a [6] = '{32'd3, 32'hFFFF0000, 32'h0000F00F, 32'd10, 32'd0, 32'd8};
    logic [31:0] burst_b [6] = '{32'd4, 32'h00FFFF00, 32'h00000FF0, 32'd20, 32'hABCD, 32'h000000FF};
    logic [4:0]  burst_c [6] = '{5'b00000, 5'b00011, 5'b01010, 5'b01000, 5'b00100, 5'b00101};

    initial begin
        int w;
        reset     = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        aluc      = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        step; do_op("add_ovf",  32'h7FFFFFFF, 32'd1,        5'b00000, 32'h80000000, 32'h0,        1'b1, 1,  w);
        step; do_op("sub_zero", 32'd5,        32'd5,        5'b01000, 32'h0,        32'h0,        1'b0, 1,  w);
        step; do_op("sub_ovf",  32'h80000000, 32'd1,        5'b01000, 32'h7FFFFFFF, 32'h0,        1'b1, 1,  w);
        step; do_op("add_neg",  32'hFFFFFFFF, 32'hFFFFFFFE, 5'b00000, 32'hFFFFFFFD, 32'h0,        1'b0, 1,  w);
        step; do_op("mul_neg",  32'hFFFFFFFD, 32'd7,        5'b00001, 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0, 33, w);
        step; do_op("mul_min",  32'h80000000, 32'h80000000, 5'b00001, 32'h0,        32'h40000000, 1'b0, 33, w);
        step; do_op("mul_pos",  32'h00012345, 32'h00010000, 5'b00001, 32'h23450000, 32'h00000001, 1'b0, 33, w);
        step; do_op("sra",      32'd4,        32'h80000000, 5'b11101, 32'hF8000000, 32'h0,        1'b0, 1,  w);
        step; do_op("srl",      32'd4,        32'h80000000, 5'b01101, 32'h08000000, 32'h0,        1'b0, 1,  w);
        step; do_op("sll",      32'd31,       32'd3,        5'b00101, 32'h80000000, 32'h0,        1'b0, 1,  w);
        step; do_op("sra_zero", 32'h00000020, 32'hDEADBEEF, 5'b11101, 32'hDEADBEEF, 32'h0,        1'b0, 1,  w);
        step; do_op("lui",      32'd0,        32'h00001234, 5'b00100, 32'h12340000, 32'h0,        1'b0, 1,  w);
        step; do_op("and",      32'h0000F0F0, 32'h0000FF00, 5'b00010, 32'h0000F000, 32'h0,        1'b0, 1,  w);
        step; do_op("or",       32'h0000F0F0, 32'h0000FF00, 5'b01010, 32'h0000FFF0, 32'h0,        1'b0, 1,  w);
        step; do_op("sel7",     32'd5,        32'd5,        5'b00111, 32'h0,        32'h0,        1'b0, 1,  w);
`ifdef ALU_MC_DIV_EN
        step; do_op("div_neg",  32'hFFFFFFF9, 32'd2,        5'b00110, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33, w);
        step; do_op("div_zero", 32'd9,        32'd0,        5'b00110, 32'hFFFFFFFF, 32'd9,        1'b0, 33, w);
        step; do_op("div_min",  32'h80000000, 32'hFFFFFFFF, 5'b00110, 32'h80000000, 32'h0,        1'b0, 33, w);
`else
        step; do_op("sel6",     32'd9,        32'd3,        5'b00110, 32'h0,        32'h0,        1'b0, 1,  w);
`endif

        // Reset in the middle of a multiply: nothing emerges, next op goes straight in
        step;
        a = 32'd100; b = 32'd200; aluc = 5'b00001; in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        repeat (10) @(posedge clock);
        #1 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        chk(out_valid == 1'b0, "rstmul_out_valid", 64'(out_valid), 64'd0);
        chk(z == 1'b1,         "rstmul_z",         64'(z),         64'd1);
        do_op("post_rst_add", 32'd1, 32'd2, 5'b00000, 32'd3, 32'h0, 1'b0, 1, w);
        chk(w == 0, "post_rst_accept_wait", 64'(w), 64'd0);

        // Backpressure: XOR result held for three cycles while another op waits
        step;
        a = 32'hFF00FF00; b = 32'h0FF00FF0; aluc = 5'b00011; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clock);
        chk(in_ready == 1'b1, "bp_accept", 64'(in_ready), 64'd1);
        step;
        a = 32'd1; b = 32'd2; aluc = 5'b00000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk(out_valid == 1'b1,    "bp_hold_valid", 64'(out_valid), 64'd1);
            chk(r == 32'hF0F0F0F0,    "bp_hold_r",     64'(r),         64'hF0F0F0F0);
            chk(in_ready == 1'b0,     "bp_hold_ready", 64'(in_ready),  64'd0);
        end
        step;
        out_ready = 1'b1;
        @(negedge clock);
        chk(in_ready == 1'b1, "bp_release_ready", 64'(in_ready), 64'd1);
        step;
        in_valid = 1'b0;
        @(negedge clock);
        chk(out_valid == 1'b1, "bp_next_valid", 64'(out_valid), 64'd1);
        chk(r == 32'd3,        "bp_next_r",     64'(r),         64'd3);

        // Back-to-back single-cycle ops at one per cycle
        step;
        for (int i = 0; i < 6; i++) begin
            a = burst_a[i]; b = burst_b[i]; aluc = burst_c[i]; in_valid = 1'b1;
            @(negedge clock);
            chk(in_ready == 1'b1, "b2b_ready", 64'(in_ready), 64'd1);
            step;
        end
        in_valid = 1'b0;
        @(negedge clock);
        chk(r == 32'h0000FF00, "b2b_last_r", 64'(r), 64'h0000FF00);

        repeat (3) @(posedge clock);
        #1;
        chk(q.size() == 0, "no_pending_results", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
